// File: rtl/keypad_pkg.sv
// Shared keypad definitions: column/row strobe patterns, key-to-position lookup and FSM states.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} kp_state_e;

    localparam logic [3:0] COL_PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0] ROW_PAT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // {col_idx, row_idx} for key codes 0x0..0xF
    localparam logic [3:0] KEY_POS [16] = '{
        4'b0011, 4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0101, 4'b1001, 4'b0010,
        4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1011, 4'b0111
    };

    function automatic logic [5:0] key_to_colrow(input logic [3:0] key);
        logic [3:0] pos;
        pos = KEY_POS[key];
        return {pos[3:2], ROW_PAT[pos[1:0]]};
    endfunction

endpackage

// File: rtl/kp_req_fifo.sv
// Key request queue: DEPTH x WIDTH synchronous FIFO, async reset, full/empty flags.
module kp_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // A full queue refuses pushes even when a pop happens in the same cycle
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + (AW+1)'(1);
        if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/keypad_emulator.sv
// Virtual 4x4 keypad: plays queued key presses onto the row lines in answer to column strobes.
// Define KEYPAD_EMU_BOUNCE_EN to add contact chatter at the start of each press and release.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 500_000,
    parameter int unsigned RELEASE_CYCLES = 500_000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned BOUNCE_CYCLES  = 2_000,
    parameter int unsigned BOUNCE_PERIOD  = 250
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    input  logic       req_valid,
    input  logic [3:0] req_key,
    output logic       req_ready,
    output logic       busy,
    output logic       key_active,
    output logic [3:0] pressed_key,
    output logic       done
);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d, row_q, row_d, row_pat, fifo_dout;
    logic             key_active_q, key_active_d, done_q, done_d;
    logic             fifo_full, fifo_empty, pop, drive, col_hit;
    logic [1:0]       col_idx;

    kp_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
        .clk   (clk_100MHz),
        .rst   (rst),
        .push  (req_valid),
        .pop   (pop),
        .din   (req_key),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int unsigned WIN_W = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int unsigned PER_W = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;

    logic [WIN_W-1:0] win_q, win_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             act_q, act_d, ph_q, ph_d;
`else
    logic unused_bounce;
    assign unused_bounce = ^{BOUNCE_CYCLES[0], BOUNCE_PERIOD[0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                key_d   = fifo_dout;
                state_d = PRESS;
                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end
            PRESS: if (cnt_q == '0) begin
                state_d = RELEASE;
                cnt_d   = CNT_W'(RELEASE_CYCLES - 1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            RELEASE: if (cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        key_active_d = (state_d == PRESS);

`ifdef KEYPAD_EMU_BOUNCE_EN
        win_d = win_q;
        per_d = per_q;
        act_d = act_q;
        ph_d  = ph_q;
        if (state_d != state_q && state_d != IDLE) begin
            // Chatter begins released on press entry and pressed on release entry
            win_d = WIN_W'(BOUNCE_CYCLES - 1);
            per_d = PER_W'(BOUNCE_PERIOD - 1);
            act_d = (BOUNCE_CYCLES != 0);
            ph_d  = (state_d == RELEASE);
        end else if (act_q) begin
            act_d = (win_q != '0);
            win_d = win_q - WIN_W'(1);
            if (per_q == '0) begin
                per_d = PER_W'(BOUNCE_PERIOD - 1);
                ph_d  = ~ph_q;
            end else begin
                per_d = per_q - PER_W'(1);
            end
        end
        drive = (state_d != IDLE) && (act_d ? ph_d : (state_d == PRESS));
`else
        drive = (state_d == PRESS);
`endif

        // Row is computed from next-cycle state so it lines up with key_active
        {col_idx, row_pat} = key_to_colrow(key_d);
        col_hit = ~&(col | COL_PAT[col_idx]);
        row_d   = (drive && col_hit) ? row_pat : '1;
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_q        <= '0;
            key_active_q <= 1'b0;
            done_q       <= 1'b0;
            row_q        <= '1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            win_q        <= '0;
            per_q        <= '0;
            act_q        <= 1'b0;
            ph_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            key_active_q <= key_active_d;
            done_q       <= done_d;
            row_q        <= row_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
            win_q        <= win_d;
            per_q        <= per_d;
            act_q        <= act_d;
            ph_q         <= ph_d;
`endif
        end
    end

    assign row         = row_q;
    assign key_active  = key_active_q;
    assign pressed_key = key_q;
    assign done        = done_q;
    assign req_ready   = !fifo_full;
    assign busy        = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD=20, RELEASE=10, FIFO depth 4.
module tb_keypad_emulator;

    logic       clk_100MHz = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;
    logic       req_valid;
    logic [3:0] req_key;
    logic       req_ready;
    logic       busy;
    logic       key_active;
    logic [3:0] pressed_key;
    logic       done;

    int checks = 0;
    int errors = 0;

    keypad_emulator #(
        .HOLD_CYCLES    (20),
        .RELEASE_CYCLES (10),
        .FIFO_DEPTH     (4),
        .BOUNCE_CYCLES  (8),
        .BOUNCE_PERIOD  (2)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst         (rst),
        .col         (col),
        .row         (row),
        .req_valid   (req_valid),
        .req_key     (req_key),
        .req_ready   (req_ready),
        .busy        (busy),
        .key_active  (key_active),
        .pressed_key (pressed_key),
        .done        (done)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #200_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic push(input logic [3:0] k);
        req_key   = k;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_ka(input logic lvl, input string tag);
        int n = 0;
        while (key_active !== lvl && n < 300) begin
            tick();
            n++;
        end
        check(tag, key_active, lvl);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    logic [3:0] col_seq [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [3:0] row_exp [4] = '{4'b1111, 4'b1111, 4'b1101, 4'b1111};
`ifdef KEYPAD_EMU_BOUNCE_EN
    logic [3:0] bp_exp [12] = '{4'hF, 4'hF, 4'hB, 4'hB, 4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB, 4'hB};
    logic [3:0] br_exp [10] = '{4'hB, 4'hB, 4'hF, 4'hF, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF};
`endif

    initial begin
        int ka_cnt;
        int n;
        rst       = 1'b1;
        col       = 4'b1111;
        req_valid = 1'b0;
        req_key   = 4'h0;

        #2;
        check("rst_row", row, 4'b1111);
        check("rst_ka", key_active, 1'b0);
        check("rst_pkey", pressed_key, 4'h0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        check("rst_ready", req_ready, 1'b1);
        tick();

        // Key 9 with column sweep, hold and release timing
        push(4'h9);
        check("t2_busy", busy, 1'b1);
        check("t2_ka_pre", key_active, 1'b0);
        tick();
        check("t2_ka_on", key_active, 1'b1);
        check("t2_pkey", pressed_key, 4'h9);
        ka_cnt = 1;
        for (int i = 0; i < 4; i++) begin
            col = col_seq[i];
            tick();
            if (key_active === 1'b1) ka_cnt++;
            check("t2_row_sweep", row, row_exp[i]);
        end
        col = 4'b1101;
        n = 0;
        while (key_active === 1'b1 && n < 100) begin
            tick();
            n++;
            if (key_active === 1'b1) ka_cnt++;
        end
        check("t2_hold_len", ka_cnt, 20);
        check("t2_row_rel", row, 4'b1111);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("t2_rel_gap", n, 10);
        tick();
        check("t2_done_pulse", done, 1'b0);
        check("t2_idle_busy", busy, 1'b0);
        check("t2_pkey_hold", pressed_key, 4'h9);

        // Queue fill: filler key pressed, then 1..4 fill the FIFO and 5 waits for space
        col = 4'b1111;
        push(4'h8);
        wait_ka(1'b1, "t3_filler_press");
        check("t3_ready_empty", req_ready, 1'b1);
        push(4'h1);
        push(4'h2);
        push(4'h3);
        check("t3_ready_pre4", req_ready, 1'b1);
        push(4'h4);
        check("t3_full", req_ready, 1'b0);
        req_key   = 4'h5;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("t3_ready_back", req_ready, 1'b1);
        check("t3_first_pkey", pressed_key, 4'h1);
        check("t3_first_ka", key_active, 1'b1);
        tick();
        req_valid = 1'b0;
        check("t3_refull", req_ready, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            wait_ka(1'b0, "t3_release");
            wait_ka(1'b1, "t3_press");
            check("t3_order", pressed_key, k);
        end
        wait_done("t3_done");
        tick();
        check("t3_busy_end", busy, 1'b0);

        // Column edge cases and key 0
        col = 4'b0000;
        push(4'hF);
        wait_ka(1'b1, "t4_F_press");
        tick();
        check("t4_F_allcols", row, 4'b1110);
        wait_done("t4_F_done");
        col = 4'b1111;
        push(4'hA);
        wait_ka(1'b1, "t4_A_press");
        tick();
        check("t4_A_nocol", row, 4'b1111);
        col = 4'b1110;
        tick();
        check("t4_A_col", row, 4'b0111);
        wait_done("t4_A_done");
        col = 4'b0111;
        push(4'h0);
        wait_ka(1'b1, "t4_0_press");
        tick();
        check("t4_0_row", row, 4'b1110);
        check("t4_0_pkey", pressed_key, 4'h0);
        wait_done("t4_0_done");

`ifdef KEYPAD_EMU_BOUNCE_EN
        col = 4'b0111;
        push(4'h4);
        wait_ka(1'b1, "t6_press");
        for (int i = 0; i < 12; i++) begin
            check("t6_press_row", row, bp_exp[i]);
            tick();
        end
        wait_ka(1'b0, "t6_release");
        for (int i = 0; i < 10; i++) begin
            check("t6_rel_row", row, br_exp[i]);
            tick();
        end
        wait_done("t6_done");
`endif

        // Reset during a press with a second key still queued
        col = 4'b1011;
        push(4'h5);
        push(4'h6);
        wait_ka(1'b1, "t1_press");
        tick();
        check("t1_row_pressed", row, 4'b1011);
        rst = 1'b1;
        #1;
        check("t1_row_async", row, 4'b1111);
        check("t1_busy", busy, 1'b0);
        check("t1_ka", key_active, 1'b0);
        #2;
        rst = 1'b0;
        repeat (3) tick();
        check("t1_busy_after", busy, 1'b0);
        check("t1_ka_after", key_active, 1'b0);
        check("t1_row_after", row, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
